// File: rtl/ram_loader.sv
// Byte-stream RAM loader: packs byte pairs into words, writes them to addresses 0..top,
// keeps a mod-256 checksum of accepted bytes and passes rd_addr through when not loading.
module ram_loader #(
    parameter int addr_width = 8,
    parameter int data_width = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    input  logic [addr_width-1:0] rd_addr,
    output logic [addr_width-1:0] ram_addr,
    output logic [data_width-1:0] ram_din,
    output logic                  ram_we,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            checksum
);

    localparam logic [addr_width-1:0] last_addr = '1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LO    = 3'd1,
        HI    = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                  state_reg;
    logic [addr_width-1:0]   load_addr_reg;
    logic [7:0]              lo_byte_reg;
    logic [data_width-1:0]   ram_din_reg;
    logic [7:0]              checksum_reg;
    logic                    ram_we_reg;
    logic                    busy_reg;
    logic                    done_reg;
    logic                    byte_ready_reg;
    logic                    accept;

    assign accept = byte_valid && byte_ready_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            load_addr_reg  <= '0;
            lo_byte_reg    <= 8'h00;
            ram_din_reg    <= '0;
            checksum_reg   <= 8'h00;
            ram_we_reg     <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            byte_ready_reg <= 1'b0;
        end else begin
            ram_we_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        load_addr_reg  <= '0;
                        checksum_reg   <= 8'h00;
                        done_reg       <= 1'b0;
                        busy_reg       <= 1'b1;
                        byte_ready_reg <= 1'b1;
                        state_reg      <= LO;
                    end
                end
                LO: begin
                    if (accept) begin
                        lo_byte_reg  <= byte_in;
                        checksum_reg <= checksum_reg + byte_in;
                        state_reg    <= HI;
                    end
                end
                HI: begin
                    // The high byte goes straight into the word register; only its low bits fit.
                    if (accept) begin
                        checksum_reg   <= checksum_reg + byte_in;
                        ram_din_reg    <= {byte_in[data_width-9:0], lo_byte_reg};
                        ram_we_reg     <= 1'b1;
                        byte_ready_reg <= 1'b0;
                        state_reg      <= WRITE;
                    end
                end
                WRITE: begin
                    if (load_addr_reg == last_addr) begin
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= DONE;
                    end else begin
                        load_addr_reg  <= load_addr_reg + addr_width'(1);
                        byte_ready_reg <= 1'b1;
                        state_reg      <= LO;
                    end
                end
                default: begin
                    busy_reg       <= 1'b0;
                    byte_ready_reg <= 1'b0;
                    state_reg      <= IDLE;
                end
            endcase
        end
    end

    assign ram_addr   = busy_reg ? load_addr_reg : rd_addr;
    assign ram_din    = ram_din_reg;
    assign ram_we     = ram_we_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign checksum   = checksum_reg;
    assign byte_ready = byte_ready_reg;

endmodule

// File: doc/ram_loader.md
# ram_loader

Sequential initiator for the single-port ROM-image RAM. It accepts a byte stream over a valid/ready handshake, packs each byte pair into one data word and writes the words to consecutive RAM addresses starting at 0 until the array is full. It keeps a running 8-bit checksum of every byte accepted. When no load is running, it passes the ROM-side read address straight through to the RAM, so the loader sits between the byte source (UART/host) and the RAM address/write port.

## Interface
Parameters:
- addr_width, 8, RAM address width; depth = 2**addr_width words
- data_width, 12, RAM word width; legal range 9..16 (exactly two bytes per word)

Ports:
- clk  input  1  single clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; begins a load at address 0 when idle or done
- byte_in  input  8  stream data byte
- byte_valid  input  1  byte_in is valid
- byte_ready  output  1  loader can accept a byte this cycle
- rd_addr  input  addr_width  ROM-side read address, used while not busy
- ram_addr  output  addr_width  RAM address
- ram_din  output  data_width  RAM write data
- ram_we  output  1  RAM write enable, registered
- busy  output  1  load in progress
- done  output  1  sticky; set when the last word is written
- checksum  output  8  sum mod 256 of all bytes accepted since the last start

## Operation
- States: IDLE, LO, HI, WRITE, DONE.
- A byte is accepted only on a cycle where byte_valid && byte_ready.
- IDLE/DONE: byte_ready=0. On start, clear load_addr, checksum and done, then go to LO.
- LO: byte_ready=1. On accept, latch lo_byte, add the byte to checksum, go to HI.
- HI: byte_ready=1. On accept, latch hi_byte, add the byte to checksum, go to WRITE.
- WRITE: ram_we=1 for exactly one cycle.
  - ram_din = {hi_byte[data_width-9:0], lo_byte}; upper unused bits of hi_byte are ignored.
  - ram_addr = load_addr.
  - If load_addr == 2**addr_width-1, go to DONE and set done; otherwise increment load_addr and go to LO.
- ram_addr mux: load_addr when busy, otherwise rd_addr (combinational passthrough).
- busy = 1 in LO, HI and WRITE.
- ram_din holds its last value outside WRITE; ram_we=0 outside WRITE.
- start while busy: ignored. A new start from DONE restarts the load and overwrites the RAM from address 0.
- byte_valid gaps of any length are allowed; the loader waits in LO or HI without timeout.
- load_addr never wraps; the load ends at the top address.
- Checksum wraps mod 256.

## Timing
- Reset values: state=IDLE, byte_ready=0, ram_we=0, busy=0, done=0, checksum=0x00, ram_din=0, load_addr=0.
- Reset mid-load returns to IDLE on the next edge with no further writes; the RAM keeps partial contents.
- start sampled at edge N → busy and byte_ready high from cycle N+1.
- Second byte accepted at edge M → ram_we high during cycle M+1, so the word commits at edge M+2.
- Maximum throughput is 3 cycles per word when byte_valid is held high.
- done and busy=0 are both asserted in the cycle after the last WRITE cycle.
- checksum updates on the same edge the byte is accepted.

## Test plan
- Reset: assert reset for 2 cycles with inputs toggling → all outputs at their reset values, and ram_addr follows rd_addr (rd_addr=0x5A gives ram_addr=0x5A).
- Small load (addr_width=2): start, then bytes 34,12,FF,FF,00,0A,01,00 → writes 0x234@0, 0xFFF@1, 0xA00@2, 0x001@3; done=1; checksum=0x4F; exactly 4 ram_we pulses.
- Backpressure: insert random 0–5 cycle byte_valid gaps during the small load → same RAM contents and checksum; no write occurs before the second byte of each pair.
- start pulse while in HI → ignored; load_addr and checksum are unchanged and the load completes normally.
- Reset asserted right after the 3rd word's first byte → IDLE next cycle; words 0–1 stay written, no further ram_we; checksum=0x00.
- Full default load (256 words, lo=i, hi=i[3:0]) → RAM[i] = {i[3:0], i}; done=1 after the 256th write; the following start clears done and checksum.
